instruction_fetch: RTL and testbench

Fetch stage and IF/ID pipeline register feeding the instruction decoder. Holds the program counter and issues word reads to a synchronous instruction SRAM with one-cycle read latency. Delivers `{instruction, pc}` pairs to the decode stage, and handles stall back-pressure from the hazard unit and PC redirects from execute (taken branch, JAL, JALR). Flushed slots are replaced by a canonical NOP.

---
 rtl/instruction_fetch.sv | 95 +++++++++
 tb/tb_instruction_fetch.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch stage plus IF/ID register: PC, synchronous SRAM request, one-entry skid
// buffer for stalls, and redirect flush to NOP.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic        id_valid,
  output logic [31:0] id_instruction,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);
  localparam logic [XLEN-1:0] PC_STEP   = XLEN'(4);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            pend_valid_q, pend_valid_d;
  logic [XLEN-1:0] pend_pc_q, pend_pc_d;
  logic            hold_valid_q, hold_valid_d;
  logic [XLEN-1:0] hold_instr_q, hold_instr_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_instr_q, id_instr_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;

  assign im_req         = !rst && !stall && !redirect;
  assign im_addr        = pc_q;
  assign id_valid       = id_valid_q;
  assign id_instruction = id_instr_q;
  assign id_pc          = id_pc_q;
  assign id_pc_plus4    = id_pc_q + PC_STEP;

  // Redirect beats stall; stall captures the single in-flight response once.
  always_comb begin
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    hold_valid_d = hold_valid_q;
    hold_instr_d = hold_instr_q;
    id_valid_d   = id_valid_q;
    id_instr_d   = id_instr_q;
    id_pc_d      = id_pc_q;
    if (redirect) begin
      pc_d         = redirect_target & WORD_MASK;
      pend_valid_d = 1'b0;
      hold_valid_d = 1'b0;
      id_valid_d   = 1'b0;
      id_instr_d   = NOP_INSTR;
    end else if (stall) begin
      if (pend_valid_q && !hold_valid_q) begin
        hold_instr_d = im_rdata;
        hold_valid_d = 1'b1;
      end
    end else begin
      pc_d         = pc_q + PC_STEP;
      pend_valid_d = 1'b1;
      pend_pc_d    = pc_q;
      id_valid_d   = pend_valid_q;
      id_pc_d      = pend_pc_q;
      id_instr_d   = hold_valid_q ? hold_instr_q : (pend_valid_q ? im_rdata : NOP_INSTR);
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC & WORD_MASK;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= '0;
      hold_valid_q <= 1'b0;
      hold_instr_q <= '0;
      id_valid_q   <= 1'b0;
      id_instr_q   <= NOP_INSTR;
      id_pc_q      <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      hold_valid_q <= hold_valid_d;
      hold_instr_q <= hold_instr_d;
      id_valid_q   <= id_valid_d;
      id_instr_q   <= id_instr_d;
      id_pc_q      <= id_pc_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Table-driven bench for instruction_fetch; SRAM returns word(a)=a, and a
// scoreboard queue tracks issued fetch addresses until they reach ID.
module tb_instruction_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] JUNK   = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        im_req;
  logic [31:0] im_addr;
  logic [31:0] im_rdata = JUNK;
  logic        id_valid;
  logic [31:0] id_instruction;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;

  instruction_fetch #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_target(redirect_target), .im_req(im_req), .im_addr(im_addr),
    .im_rdata(im_rdata), .id_valid(id_valid), .id_instruction(id_instruction),
    .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
  );

  always #5 clk = ~clk;

  // One-cycle-latency SRAM; garbage when not requested so a lost response shows.
  always_ff @(posedge clk) im_rdata <= im_req ? im_addr : JUNK;

  typedef struct {
    logic        r;
    logic        s;
    logic        rd;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic        e_chkpc;
    logic [31:0] e_pc;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] sb[$];
  logic [31:0] last_instr;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int row);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic rd, input logic [31:0] tgt,
                     input logic e_req, input logic [31:0] e_addr,
                     input logic e_valid, input logic e_chkpc, input logic [31:0] e_pc);
    vec_t v;
    v = '{r, s, rd, tgt, e_req, e_addr, e_valid, e_chkpc, e_pc};
    tbl.push_back(v);
  endtask

  initial begin
    //   r  s  rd tgt            req addr           vld cpc pc
    add(1, 0, 0, 0,             0, 0,             0, 1, 32'h0);          // 0 reset
    add(1, 0, 0, 0,             0, 0,             0, 1, 32'h0);          // 1
    add(0, 0, 0, 0,             1, 32'h100,       0, 0, 0);              // 2 first request
    add(0, 0, 0, 0,             1, 32'h104,       1, 1, 32'h100);        // 3
    add(0, 0, 0, 0,             1, 32'h108,       1, 1, 32'h104);        // 4
    add(0, 1, 0, 0,             0, 0,             1, 1, 32'h104);        // 5 stall x3
    add(0, 1, 0, 0,             0, 0,             1, 1, 32'h104);        // 6
    add(0, 1, 0, 0,             0, 0,             1, 1, 32'h104);        // 7
    add(0, 0, 0, 0,             1, 32'h10C,       1, 1, 32'h108);        // 8 skid drains
    add(0, 0, 0, 0,             1, 32'h110,       1, 1, 32'h10C);        // 9
    add(0, 0, 1, 32'h2002,      0, 0,             0, 1, 32'h10C);        // 10 redirect
    add(0, 0, 0, 0,             1, 32'h2000,      0, 0, 0);              // 11 bubble
    add(0, 0, 0, 0,             1, 32'h2004,      1, 1, 32'h2000);       // 12
    add(0, 0, 0, 0,             1, 32'h2008,      1, 1, 32'h2004);       // 13
    add(0, 1, 0, 0,             0, 0,             1, 1, 32'h2004);       // 14 fill skid
    add(0, 1, 1, 32'h3000,      0, 0,             0, 1, 32'h2004);       // 15 stall+redirect
    add(0, 0, 0, 0,             1, 32'h3000,      0, 0, 0);              // 16
    add(0, 0, 0, 0,             1, 32'h3004,      1, 1, 32'h3000);       // 17
    add(0, 0, 0, 0,             1, 32'h3008,      1, 1, 32'h3004);       // 18
    add(0, 0, 1, 32'hFFFF_FFFE, 0, 0,             0, 1, 32'h3004);       // 19 redirect near top
    add(0, 0, 0, 0,             1, 32'hFFFF_FFFC, 0, 0, 0);              // 20
    add(0, 0, 0, 0,             1, 32'h0,         1, 1, 32'hFFFF_FFFC);  // 21 wrap
    add(0, 0, 0, 0,             1, 32'h4,         1, 1, 32'h0);          // 22
    add(0, 1, 0, 0,             0, 0,             1, 1, 32'h0);          // 23 fill skid
    add(0, 1, 0, 0,             0, 0,             1, 1, 32'h0);          // 24
    add(1, 1, 0, 0,             0, 0,             0, 1, 32'h0);          // 25 reset mid-stall
    add(0, 0, 0, 0,             1, 32'h100,       0, 0, 0);              // 26 refetch
    add(0, 0, 0, 0,             1, 32'h104,       1, 1, 32'h100);        // 27
    add(0, 1, 0, 0,             0, 0,             1, 1, 32'h100);        // 28 stall, gap, stall
    add(0, 0, 0, 0,             1, 32'h108,       1, 1, 32'h104);        // 29
    add(0, 1, 0, 0,             0, 0,             1, 1, 32'h104);        // 30
    add(0, 0, 0, 0,             1, 32'h10C,       1, 1, 32'h108);        // 31
    add(0, 0, 0, 0,             1, 32'h110,       1, 1, 32'h10C);        // 32

    last_instr = NOP;
    for (int i = 0; i < tbl.size(); i++) begin
      logic deliver;
      @(negedge clk);
      rst             = tbl[i].r;
      stall           = tbl[i].s;
      redirect        = tbl[i].rd;
      redirect_target = tbl[i].tgt;
      #1;
      chk("im_req", 32'(im_req), 32'(tbl[i].e_req), i);
      if (tbl[i].e_req) begin
        chk("im_addr", im_addr, tbl[i].e_addr, i);
        sb.push_back(tbl[i].e_addr);
      end
      deliver = !tbl[i].r && !tbl[i].rd && !tbl[i].s && tbl[i].e_valid;
      @(posedge clk);
      #1;
      if (tbl[i].r || tbl[i].rd) sb.delete();
      chk("id_valid", 32'(id_valid), 32'(tbl[i].e_valid), i);
      if (tbl[i].e_chkpc) begin
        chk("id_pc", id_pc, tbl[i].e_pc, i);
        chk("id_pc_plus4", id_pc_plus4, tbl[i].e_pc + 32'd4, i);
      end
      if (deliver) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard row %0d: delivery with no outstanding fetch", i);
        end else begin
          last_instr = sb.pop_front();
        end
      end
      if (tbl[i].e_valid) chk("id_instruction", id_instruction, last_instr, i);
      else                chk("id_nop", id_instruction, NOP, i);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
